// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-pin and response bundle between the op sequencer (master) and its
// surroundings (slave: requester, combinational ALU and response consumer).
interface alu_op_sequencer_if #(
   parameter int N = 16,
   parameter int M = 4
);
   logic         req_valid;
   logic         req_ready;
   logic [M-1:0] req_mode;
   logic [N-1:0] req_a;
   logic [N-1:0] req_b;
   logic         req_cin;
   logic         req_chain;

   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic         alu_cin;
   logic [M-1:0] alu_mode;
   logic [N-1:0] alu_y;
   logic         alu_cout;
   logic         alu_ovf;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_y;
   logic         rsp_cout;
   logic         rsp_ovf;

   modport master (
      input  req_valid, req_mode, req_a, req_b, req_cin, req_chain,
      input  alu_y, alu_cout, alu_ovf,
      input  rsp_ready,
      output req_ready,
      output alu_a, alu_b, alu_cin, alu_mode,
      output rsp_valid, rsp_y, rsp_cout, rsp_ovf
   );

   modport slave (
      output req_valid, req_mode, req_a, req_b, req_cin, req_chain,
      output alu_y, alu_cout, alu_ovf,
      output rsp_ready,
      input  req_ready,
      input  alu_a, alu_b, alu_cin, alu_mode,
      input  rsp_valid, rsp_y, rsp_cout, rsp_ovf
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: response 2 clocks after accept, one op in flight; req_ready stays low
// until the response retires. Sticky carry/overflow flags via ALU_OP_SEQUENCER_STICKY_FLAGS_EN.
module alu_op_sequencer #(
   parameter int N = 16,
   parameter int M = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_op_sequencer_if.master bus,
`ifdef ALU_OP_SEQUENCER_STICKY_FLAGS_EN
   input  logic               flag_clr,
   output logic               sticky_cout,
   output logic               sticky_ovf,
`endif
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_next_state;
   logic         w_accept;
   logic         w_retire;

   logic [N-1:0] r_acc;
   logic [N-1:0] r_alu_a;
   logic [N-1:0] r_alu_b;
   logic         r_alu_cin;
   logic [M-1:0] r_alu_mode;

   logic         r_rsp_valid;
   logic [N-1:0] r_rsp_y;
   logic         r_rsp_cout;
   logic         r_rsp_ovf;

   assign w_accept = (r_state == S_IDLE) && bus.req_valid;
   assign w_retire = (r_state == S_RESP) && r_rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_EXEC;
         S_EXEC:  w_next_state = S_RESP;
         S_RESP:  if (w_retire) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ALU pins only move on accept, so the ALU sees a stable operand set otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_cin  <= 1'b0;
         r_alu_mode <= '0;
      end else if (w_accept) begin
         r_alu_a    <= bus.req_chain ? r_acc : bus.req_a;
         r_alu_b    <= bus.req_b;
         r_alu_cin  <= bus.req_cin;
         r_alu_mode <= bus.req_mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_y     <= '0;
         r_rsp_cout  <= 1'b0;
         r_rsp_ovf   <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_acc       <= bus.alu_y;
         r_rsp_valid <= 1'b1;
         r_rsp_y     <= bus.alu_y;
         r_rsp_cout  <= bus.alu_cout;
         r_rsp_ovf   <= bus.alu_ovf;
      end else if (w_retire) begin
         r_rsp_valid <= 1'b0;
      end
   end

`ifdef ALU_OP_SEQUENCER_STICKY_FLAGS_EN
   logic r_sticky_cout;
   logic r_sticky_ovf;

   // A flag raised on the same edge as a clear survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_cout <= 1'b0;
         r_sticky_ovf  <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_sticky_cout <= (r_sticky_cout & ~flag_clr) | bus.alu_cout;
         r_sticky_ovf  <= (r_sticky_ovf  & ~flag_clr) | bus.alu_ovf;
      end else if (flag_clr) begin
         r_sticky_cout <= 1'b0;
         r_sticky_ovf  <= 1'b0;
      end
   end

   assign sticky_cout = r_sticky_cout;
   assign sticky_ovf  = r_sticky_ovf;
`endif

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_cin   = r_alu_cin;
   assign bus.alu_mode  = r_alu_mode;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_y     = r_rsp_y;
   assign bus.rsp_cout  = r_rsp_cout;
   assign bus.rsp_ovf   = r_rsp_ovf;
   assign busy          = (r_state != S_IDLE);

endmodule
